// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the cache-channel request/reply signals and the
// shared line-memory backend port of mem_arbiter.
// slave  : the arbiter's view (takes cache requests and backend replies)
// master : the environment's view (caches plus backend model)
interface mem_arbiter_if #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 64
);
  logic [NCH-1:0]        req_i;
  logic [NCH*ADDR_W-1:0] addr_i;
  logic [NCH-1:0]        write_i;
  logic [NCH*32-1:0]     wdata_i;
  logic [NCH*4-1:0]      wmask_i;
  logic [NCH-1:0]        rep_o;
  logic [LINE_W-1:0]     rep_data_o;
  logic [NCH-1:0]        grant_o;
  logic                  busy_o;
  logic                  mem_req_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic                  mem_write_o;
  logic [31:0]           mem_wdata_o;
  logic [3:0]            mem_wmask_o;
  logic                  mem_rep_i;
  logic [LINE_W-1:0]     mem_rep_data_i;

  modport slave (
    input  req_i, addr_i, write_i, wdata_i, wmask_i, mem_rep_i, mem_rep_data_i,
    output rep_o, rep_data_o, grant_o, busy_o,
    output mem_req_o, mem_addr_o, mem_write_o, mem_wdata_o, mem_wmask_o
  );

  modport master (
    output req_i, addr_i, write_i, wdata_i, wmask_i, mem_rep_i, mem_rep_data_i,
    input  rep_o, rep_data_o, grant_o, busy_o,
    input  mem_req_o, mem_addr_o, mem_write_o, mem_wdata_o, mem_wmask_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises line-fill / write requests from NCH cache channels
// onto one request/reply line-memory port and routes each reply back to the
// channel that issued it. Round-robin by default; defining
// MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins, no pointer).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no transaction; arbitrate on every edge
// ISSUE   | mem_req_o pulses; a same-cycle backend reply goes to REPLY
// WAIT    | waiting (unbounded) for mem_rep_i
// REPLY   | rep_o pulses to the owner; pointer advances on exit
module mem_arbiter #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 64
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_REPLY = 2'd3;

  logic [1:0]        r_state;
  logic [NCH-1:0]    r_grant;
  logic [NCH-1:0]    r_rep;
  logic              r_busy;
  logic              r_mem_req;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_wmask;
  logic [LINE_W-1:0] r_rep_data;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_gidx;
`endif

  logic [IW-1:0]     w_win;
  logic              w_any;
  logic [NCH-1:0]    w_req_rot;
  int                w_idx;
  logic [NCH-1:0]    w_onehot;
  logic [NCH-1:0]    w_wr_rot;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [3:0]        w_wmask;

  // Winner search: first requesting channel starting from the pointer
  // (or from channel 0 in fixed-priority builds), wrapping past NCH-1.
  always_comb begin
    w_win     = '0;
    w_any     = 1'b0;
    w_idx     = 0;
    w_req_rot = '0;
    for (int i = 0; i < NCH; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      w_idx = i;
`else
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NCH) w_idx = w_idx - NCH;
`endif
      w_req_rot = bus.req_i >> w_idx;
      if (!w_any && w_req_rot[0]) begin
        w_any = 1'b1;
        w_win = IW'(w_idx);
      end
    end
  end

  // Winner's request fields, extracted by shifting the packed channel buses.
  assign w_onehot = NCH'(1) << w_win;
  assign w_wr_rot = bus.write_i >> w_win;
  assign w_addr   = ADDR_W'(bus.addr_i >> (int'(w_win) * ADDR_W));
  assign w_wdata  = 32'(bus.wdata_i >> (int'(w_win) * 32));
  assign w_wmask  = 4'(bus.wmask_i >> (int'(w_win) * 4));

  // Control FSM: state, owner, busy, one-cycle pulses and pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_rep     <= '0;
      r_busy    <= 1'b0;
      r_mem_req <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_ptr     <= '0;
      r_gidx    <= '0;
`endif
    end else begin
      r_mem_req <= 1'b0;
      r_rep     <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state   <= S_ISSUE;
            r_grant   <= w_onehot;
            r_busy    <= 1'b1;
            r_mem_req <= 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_gidx    <= w_win;
`endif
          end
        end
        S_ISSUE, S_WAIT: begin
          if (bus.mem_rep_i) begin
            r_state <= S_REPLY;
            r_rep   <= r_grant;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_REPLY: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          r_ptr   <= (r_gidx == IW'(NCH - 1)) ? '0 : r_gidx + 1'b1;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: latch the winner's request at grant, capture the backend reply.
  // Held values ignore every channel input until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_addr  <= '0;
      r_mem_write <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_rep_data  <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_mem_addr  <= w_addr;
        r_mem_write <= w_wr_rot[0];
        r_mem_wdata <= w_wdata;
        r_mem_wmask <= w_wmask;
      end
      if ((r_state == S_ISSUE || r_state == S_WAIT) && bus.mem_rep_i) begin
        r_rep_data <= bus.mem_rep_data_i;
      end
    end
  end

  assign bus.rep_o       = r_rep;
  assign bus.rep_data_o  = r_rep_data;
  assign bus.grant_o     = r_grant;
  assign bus.busy_o      = r_busy;
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_write_o = r_mem_write;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.mem_wmask_o = r_mem_wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one NCH=2 and one NCH=4 instance share the clock,
// reset and stimulus variables; 'sel' picks which instance is exercised.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  int          sel;
  int          total;
  int          bad;
  int          ptr_m [2];
  logic [63:0] last_rd;

  logic [3:0]  req;
  logic [3:0]  wr;
  logic [31:0] addr [4];
  logic [31:0] wdat [4];
  logic [3:0]  msk  [4];
  logic        mrep;
  logic [63:0] mrdata;

  logic [3:0]  o_rep, o_grant, o_mmask;
  logic        o_busy, o_mreq, o_mwrite;
  logic [31:0] o_maddr, o_mwdata;
  logic [63:0] o_rdata;

  mem_arbiter_if #(.NCH(2), .ADDR_W(32), .LINE_W(64)) if2 ();
  mem_arbiter_if #(.NCH(4), .ADDR_W(32), .LINE_W(64)) if4 ();

  mem_arbiter #(.NCH(2), .ADDR_W(32), .LINE_W(64)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  mem_arbiter #(.NCH(4), .ADDR_W(32), .LINE_W(64)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  assign if2.req_i          = (sel == 0) ? req[1:0] : 2'b00;
  assign if2.addr_i         = {addr[1], addr[0]};
  assign if2.write_i        = wr[1:0];
  assign if2.wdata_i        = {wdat[1], wdat[0]};
  assign if2.wmask_i        = {msk[1], msk[0]};
  assign if2.mem_rep_i      = (sel == 0) && mrep;
  assign if2.mem_rep_data_i = mrdata;

  assign if4.req_i          = (sel == 1) ? req : 4'b0000;
  assign if4.addr_i         = {addr[3], addr[2], addr[1], addr[0]};
  assign if4.write_i        = wr;
  assign if4.wdata_i        = {wdat[3], wdat[2], wdat[1], wdat[0]};
  assign if4.wmask_i        = {msk[3], msk[2], msk[1], msk[0]};
  assign if4.mem_rep_i      = (sel == 1) && mrep;
  assign if4.mem_rep_data_i = mrdata;

  assign o_rep    = (sel == 0) ? {2'b00, if2.rep_o}   : if4.rep_o;
  assign o_grant  = (sel == 0) ? {2'b00, if2.grant_o} : if4.grant_o;
  assign o_busy   = (sel == 0) ? if2.busy_o      : if4.busy_o;
  assign o_mreq   = (sel == 0) ? if2.mem_req_o   : if4.mem_req_o;
  assign o_mwrite = (sel == 0) ? if2.mem_write_o : if4.mem_write_o;
  assign o_maddr  = (sel == 0) ? if2.mem_addr_o  : if4.mem_addr_o;
  assign o_mwdata = (sel == 0) ? if2.mem_wdata_o : if4.mem_wdata_o;
  assign o_mmask  = (sel == 0) ? if2.mem_wmask_o : if4.mem_wmask_o;
  assign o_rdata  = (sel == 0) ? if2.rep_data_o  : if4.rep_data_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration rule: scan upward from the pointer with wrap.
  function automatic int winner(input logic [3:0] r, input int p, input int n);
    for (int d = 0; d < n; d++) begin
      int c;
      c = (p + d) % n;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rep"},   o_rep,   4'h0);
    chk({tag, "_grant"}, o_grant, 4'h0);
    chk({tag, "_busy"},  o_busy,  1'b0);
    chk({tag, "_mreq"},  o_mreq,  1'b0);
  endtask

  // One transaction of the selected instance, from the arbitration edge to the
  // following IDLE cycle. Entered and left between edges with the instance idle.
  task automatic txn(input int dly, input bit rereq, input bit withdraw, input logic [63:0] data);
    int n, g;
    logic [31:0] ea, ew;
    logic [3:0]  em, oh;
    logic        ewr;
    n = (sel == 0) ? 2 : 4;
    g = winner(req, ptr_m[sel], n);
    if (g < 0) $fatal(1, "FAIL txn_request obs=none exp=some");
    ea = addr[g]; ew = wdat[g]; em = msk[g]; ewr = wr[g];
    oh = 4'(1 << g);
    @(posedge clk);
    @(negedge clk);
    chk("issue_grant", o_grant, oh);
    chk("issue_busy",  o_busy,  1'b1);
    chk("issue_mreq",  o_mreq,  1'b1);
    chk("issue_addr",  o_maddr, ea);
    chk("issue_write", o_mwrite, ewr);
    chk("issue_wdata", o_mwdata, ew);
    chk("issue_wmask", o_mmask, em);
    chk("issue_rep",   o_rep,   4'h0);
    for (int w = 0; w < dly; w++) begin
      if (withdraw && w == 0) req[g] = 1'b0;
      for (int c = 0; c < n; c++) begin
        if (c != g) begin
          addr[c] = $urandom; wdat[c] = $urandom; msk[c] = 4'($urandom);
        end
      end
      @(negedge clk);
      chk("wait_mreq",  o_mreq,   1'b0);
      chk("wait_busy",  o_busy,   1'b1);
      chk("wait_grant", o_grant,  oh);
      chk("wait_addr",  o_maddr,  ea);
      chk("wait_write", o_mwrite, ewr);
      chk("wait_wdata", o_mwdata, ew);
      chk("wait_wmask", o_mmask,  em);
      chk("wait_rep",   o_rep,    4'h0);
    end
    mrep = 1'b1; mrdata = data;
    @(negedge clk);
    mrep = 1'b0; mrdata = {$urandom, $urandom};
    chk("reply_rep",   o_rep,   oh);
    chk("reply_data",  o_rdata, data);
    chk("reply_busy",  o_busy,  1'b1);
    chk("reply_mreq",  o_mreq,  1'b0);
    chk("reply_grant", o_grant, oh);
    @(posedge clk);
    #1 req[g] = rereq;
`ifndef MEM_ARB_FIXED_PRIO_EN
    ptr_m[sel] = (g + 1) % n;
`endif
    last_rd = data;
    @(negedge clk);
    chk_idle_outputs("idle");
    chk("idle_data", o_rdata, data);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 8; k++) begin
      if (winner(req, ptr_m[sel], n) >= 0) txn($urandom_range(0, 2), 1'b0, 1'b0, {$urandom, $urandom});
    end
  endtask

  task automatic rand_block(input int n, input int count);
    for (int t = 0; t < count; t++) begin
      for (int c = 0; c < n; c++) begin
        if (!req[c] && $urandom_range(0, 1) == 1) begin
          addr[c] = $urandom; wdat[c] = $urandom; msk[c] = 4'($urandom);
          wr[c] = 1'($urandom_range(0, 1)); req[c] = 1'b1;
        end
      end
      if (winner(req, 0, n) < 0) req[$urandom_range(0, n - 1)] = 1'b1;
      txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          {$urandom, $urandom});
    end
    drain(n);
  endtask

  initial begin
    total = 0; bad = 0; sel = 0; ptr_m[0] = 0; ptr_m[1] = 0; last_rd = '0;
    req = '0; wr = '0; mrep = 1'b0; mrdata = '0;
    for (int c = 0; c < 4; c++) begin addr[c] = '0; wdat[c] = '0; msk[c] = '0; end
    rst = 1'b0;

    // reset state of both instances
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      chk_idle_outputs("rst0");
      chk("rst0_mwrite", o_mwrite, 1'b0);
      chk("rst0_maddr",  o_maddr,  32'h0);
      chk("rst0_mwdata", o_mwdata, 32'h0);
      chk("rst0_mmask",  o_mmask,  4'h0);
      chk("rst0_rdata",  o_rdata,  64'h0);
    end
    sel = 0;
    #3 rst = 1'b1;
    @(negedge clk);

    // contention from reset: both held, alternating grants, then drained
    addr[0] = 32'h1000; addr[1] = 32'h2000; req = 4'b0011;
    for (int k = 0; k < 4; k++) txn(0, 1'b1, 1'b0, {$urandom, $urandom});
    drain(2);

    // single read, zero-wait backend
    req[0] = 1'b1; addr[0] = 32'h100; wr[0] = 1'b0;
    txn(0, 1'b0, 1'b0, 64'hDEADBEEF_01234567);

    // write on ch1 with a 3-cycle backend
    req[1] = 1'b1; addr[1] = 32'h40; wdat[1] = 32'hA5A5A5A5; msk[1] = 4'b0011; wr[1] = 1'b1;
    txn(3, 1'b0, 1'b0, {$urandom, $urandom});

    // withdrawal during WAIT
    req[0] = 1'b1; addr[0] = 32'h180; wr[0] = 1'b0;
    txn(2, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);

    // stray reply in IDLE
    mrep = 1'b1; mrdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    mrep = 1'b0;
    chk_idle_outputs("stray");
    chk("stray_data", o_rdata, last_rd);
    @(negedge clk);
    chk("stray_rep2", o_rep, 4'h0);

    // asynchronous reset while in WAIT
    req[0] = 1'b1; addr[0] = 32'h200; wr[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 chk("arst_pre_busy", o_busy, 1'b1);
    rst = 1'b0;
    #1;
    chk_idle_outputs("arst");
    chk("arst_maddr", o_maddr, 32'h0);
    req[0] = 1'b0;
    ptr_m[0] = 0; ptr_m[1] = 0;
    #3 rst = 1'b1;
    @(negedge clk);
    mrep = 1'b1;
    @(negedge clk);
    mrep = 1'b0;
    chk_idle_outputs("late_rep");
    @(negedge clk);
    chk("late_rep2", o_rep, 4'h0);

    // NCH=4: pointer to 3, then ch1 and ch2 compete across the wrap
    sel = 1;
    req[2] = 1'b1; addr[2] = 32'h300;
    txn(1, 1'b0, 1'b0, {$urandom, $urandom});
    req[1] = 1'b1; req[2] = 1'b1; addr[1] = 32'h410; addr[2] = 32'h420;
    txn(0, 1'b0, 1'b0, {$urandom, $urandom});
    txn(0, 1'b0, 1'b0, {$urandom, $urandom});

    // randomized traffic on both instances
    rand_block(4, 24);
    req = '0;
    sel = 0;
    rand_block(2, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
